alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 SHALL have port aluControl  input  4  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 MUL, 9-15 illegal.
REQ-006 SHALL have ports operandA, operandB  input  WIDTH  source operands; shift amount is operandB[3:0].
REQ-007 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port result  output  WIDTH  registered result; holds until next done.
REQ-010 SHALL have ports zero, overflow, illegal  output  1 each  flags, updated only with done.

Function
REQ-011 SHALL latch aluControl, operandA, operandB on the clock edge where start=1 and state=IDLE; inputs are don't-care afterwards.
REQ-012 SHALL ignore start while busy=1 or done=1; no queuing.
REQ-013 SHALL implement states IDLE, SHIFT, MUL, DONE.
REQ-014 IDLE + start with code 0-5 or 9-15 -> DONE; result computed from latched operands; done=1 one cycle after start edge (latency 1).
REQ-015 IDLE + start with code 6/7 -> SHIFT with counter = operandB[3:0]; counter 0 -> DONE directly (latency 1).
REQ-016 SHIFT: shift working register one bit per cycle (SLL: left, zero fill; SRL: right, logical, zero fill), decrement counter; counter reaching 0 -> DONE; latency = N+1 cycles for amount N.
REQ-017 IDLE + start with code 8 -> MUL; shift-add unsigned multiply, one multiplier bit per cycle, exactly WIDTH iterations; then DONE; latency WIDTH+1 (17 at default).
REQ-018 MUL result SHALL be low WIDTH bits of product; overflow=1 iff any of the upper WIDTH product bits is nonzero.
REQ-019 ADD/SUB SHALL be WIDTH-bit modular; overflow=1 on two's-complement signed overflow; overflow=0 for codes 2-7.
REQ-020 Codes 9-15: result=0, zero=1, overflow=0, illegal=1; illegal=0 for all legal codes.
REQ-021 zero SHALL equal (result==0) for the same done.
REQ-022 DONE: done=1, busy=0 for exactly one cycle, then IDLE; a start in DONE cycle is ignored, next acceptable start is the following cycle.
REQ-023 result and flags SHALL hold their values from done until the next done.
REQ-024 busy=1 in SHIFT and MUL states only.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, zero=0, overflow=0, illegal=0, counters=0, independent of clk.
REQ-026 Reset asserted mid-SHIFT or mid-MUL SHALL abort the operation with no done pulse; first start after rst_n rises on a clock edge is accepted normally.

Verification
REQ-027 ADD A=0x7FFF B=0x0001 -> done 1 cycle after start, result=0x8000, overflow=1, zero=0.
REQ-028 SUB A=0x1234 B=0x1234 -> result=0x0000, zero=1, overflow=0, latency 1.
REQ-029 SLL A=0x0001 B=0x0005 -> busy 5 cycles, done at cycle 6, result=0x0020; SRL B=0 -> done at cycle 1, result=A.
REQ-030 MUL A=0x0100 B=0x0100 -> done at cycle 17, result=0x0000, overflow=1, zero=1; MUL 3x5 -> result=0x000F, overflow=0.
REQ-031 start pulsed during MUL busy with code ADD -> ignored, MUL result unaffected; code 0xC -> result=0, illegal=1.
REQ-032 rst_n low at cycle 8 of MUL -> outputs zero immediately, no done; new ADD 2+3 after release -> result=0x0005.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: operation request from the master,
// busy/done handshake and registered result plus flags from the execution unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       aluControl;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, aluControl, operandA, operandB,
    input  busy, done, result, zero, overflow, illegal
  );

  modport slave (
    input  start, aluControl, operandA, operandB,
    output busy, done, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts and a
// shift-add unsigned multiplier, sequenced by an IDLE/SHIFT/MUL/DONE FSM.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOR = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8
  } aluOp_e;

  // Wide enough for both the 4-bit shift amount and the WIDTH multiply iterations.
  localparam int CNT_W = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state;
  logic             opLeft;
  logic [CNT_W-1:0] iterCount;
  logic [WIDTH-1:0] workReg;
  logic [WIDTH-1:0] prodHi;
  logic [WIDTH-1:0] prodLo;

  logic [WIDTH-1:0] sumAB;
  logic [WIDTH-1:0] diffAB;
  logic [WIDTH-1:0] quickResult;
  logic             quickOverflow;
  logic             quickIllegal;
  logic             isShiftOp;
  logic             isMulOp;

  logic [WIDTH-1:0]   shiftNext;
  logic [WIDTH:0]     partialSum;
  logic [2*WIDTH-1:0] prodNext;

  logic             finishNow;
  logic [WIDTH-1:0] finishResult;
  logic             finishOverflow;
  logic             finishIllegal;

  // Single-cycle operations evaluated straight from the operands present at the start edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sumAB         = bus.operandA + bus.operandB;
    diffAB        = bus.operandA - bus.operandB;
    quickResult   = '0;
    quickOverflow = 1'b0;
    quickIllegal  = 1'b0;
    case (bus.aluControl)
      OP_ADD: begin
        quickResult   = sumAB;
        quickOverflow = (bus.operandA[WIDTH-1] == bus.operandB[WIDTH-1]) &&
                        (sumAB[WIDTH-1] != bus.operandA[WIDTH-1]);
      end
      OP_SUB: begin
        quickResult   = diffAB;
        quickOverflow = (bus.operandA[WIDTH-1] != bus.operandB[WIDTH-1]) &&
                        (diffAB[WIDTH-1] != bus.operandA[WIDTH-1]);
      end
      OP_AND: quickResult = bus.operandA & bus.operandB;
      OP_OR:  quickResult = bus.operandA | bus.operandB;
      OP_XOR: quickResult = bus.operandA ^ bus.operandB;
      OP_NOR: quickResult = ~(bus.operandA | bus.operandB);
      OP_SLL, OP_SRL, OP_MUL: quickResult = '0;
      default: quickIllegal = 1'b1;
    endcase
  end

  assign isShiftOp = (bus.aluControl == OP_SLL) || (bus.aluControl == OP_SRL);
  assign isMulOp   = (bus.aluControl == OP_MUL);

  // One shift step, and one multiply step on the right-shifting {prodHi, prodLo} product.
  always_comb begin
    shiftNext  = opLeft ? (workReg << 1) : (workReg >> 1);
    partialSum = prodLo[0] ? ({1'b0, prodHi} + {1'b0, workReg}) : {1'b0, prodHi};
    prodNext   = {partialSum, prodLo[WIDTH-1:1]};
  end

  // Decide whether this edge completes an operation, and with which result.
  always_comb begin
    finishNow      = 1'b0;
    finishResult   = quickResult;
    finishOverflow = quickOverflow;
    finishIllegal  = quickIllegal;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (isShiftOp) begin
            finishNow      = (bus.operandB[3:0] == 4'd0);
            finishResult   = bus.operandA;
            finishOverflow = 1'b0;
            finishIllegal  = 1'b0;
          end else begin
            finishNow = !isMulOp;
          end
        end
      end
      SHIFT: begin
        finishNow      = (iterCount == CNT_ONE);
        finishResult   = shiftNext;
        finishOverflow = 1'b0;
        finishIllegal  = 1'b0;
      end
      MUL: begin
        finishNow      = (iterCount == CNT_ONE);
        finishResult   = prodNext[WIDTH-1:0];
        finishOverflow = |prodNext[2*WIDTH-1:WIDTH];
        finishIllegal  = 1'b0;
      end
      default: finishNow = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      opLeft       <= 1'b0;
      iterCount    <= '0;
      workReg      <= '0;
      prodHi       <= '0;
      prodLo       <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.zero     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.illegal  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; the later finishNow block overrides earlier writes this edge.
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opLeft  <= (bus.aluControl == OP_SLL);
            workReg <= bus.operandA;
            prodHi  <= '0;
            prodLo  <= bus.operandB;
            if (isMulOp) begin
              state     <= MUL;
              bus.busy  <= 1'b1;
              iterCount <= CNT_W'(WIDTH);
            end else if (isShiftOp) begin
              state     <= SHIFT;
              bus.busy  <= 1'b1;
              iterCount <= CNT_W'(bus.operandB[3:0]);
            end
          end
        end
        SHIFT: begin
          workReg   <= shiftNext;
          iterCount <= iterCount - CNT_ONE;
        end
        MUL: begin
          prodHi    <= prodNext[2*WIDTH-1:WIDTH];
          prodLo    <= prodNext[WIDTH-1:0];
          iterCount <= iterCount - CNT_ONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (finishNow) begin
        state        <= DONE;
        bus.busy     <= 1'b0;
        bus.done     <= 1'b1;
        bus.result   <= finishResult;
        bus.zero     <= (finishResult == '0);
        bus.overflow <= finishOverflow;
        bus.illegal  <= finishIllegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: latency, results, flags,
// start-ignore behaviour and asynchronous reset abort.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   passCount;
  int   totalCount;

  alu_exec_unit_if #(.WIDTH(16)) bus ();

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation on a negedge, then watch each following negedge until done.
  task automatic runOp(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output int busyCyc);
    @(negedge clk);
    bus.start = 1'b1; bus.aluControl = ctrl; bus.operandA = a; bus.operandB = b;
    lat = -1;
    busyCyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.aluControl = 4'hF;
      bus.operandA = 16'($urandom);
      bus.operandB = 16'($urandom);
      if (bus.busy) busyCyc++;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic expectOp(input string name, input logic [3:0] ctrl, input logic [15:0] a,
                          input logic [15:0] b, input int expLat, input logic [15:0] expRes,
                          input logic expZero, input logic expOv, input logic expIll);
    int lat;
    int busyCyc;
    runOp(ctrl, a, b, lat, busyCyc);
    totalCount++;
    if (lat !== expLat) $display("FAIL %s latency: got %0d expected %0d", name, lat, expLat);
    else passCount++;
    totalCount++;
    if (busyCyc !== expLat - 1) $display("FAIL %s busy cycles: got %0d expected %0d", name, busyCyc, expLat - 1);
    else passCount++;
    totalCount++;
    if ({bus.result, bus.zero, bus.overflow, bus.illegal} !== {expRes, expZero, expOv, expIll})
      $display("FAIL %s result/z/ov/ill: got %h/%b/%b/%b expected %h/%b/%b/%b", name,
               bus.result, bus.zero, bus.overflow, bus.illegal, expRes, expZero, expOv, expIll);
    else passCount++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.aluControl = 4'd0; bus.operandA = '0; bus.operandB = '0;
    #3;
    totalCount++;
    if ({bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.illegal} !== 21'd0)
      $display("FAIL reset outputs: got busy=%b done=%b res=%h z=%b ov=%b ill=%b expected all 0",
               bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.illegal);
    else passCount++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    expectOp("add_ovf",  4'd0, 16'h7FFF, 16'h0001, 1, 16'h8000, 1'b0, 1'b1, 1'b0);
    expectOp("sub_zero", 4'd1, 16'h1234, 16'h1234, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
    expectOp("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
    expectOp("sub_ovf",  4'd1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_logic();
    expectOp("and", 4'd2, 16'hF0F0, 16'h0FF0, 1, 16'h00F0, 1'b0, 1'b0, 1'b0);
    expectOp("or",  4'd3, 16'hF0F0, 16'h0FF0, 1, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    expectOp("xor", 4'd4, 16'hF0F0, 16'h0FF0, 1, 16'hFF00, 1'b0, 1'b0, 1'b0);
    expectOp("nor", 4'd5, 16'hF0F0, 16'h0FF0, 1, 16'h000F, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_shift();
    expectOp("sll5",    4'd6, 16'h0001, 16'h0005, 6,  16'h0020, 1'b0, 1'b0, 1'b0);
    expectOp("srl0",    4'd7, 16'hABCD, 16'h0000, 1,  16'hABCD, 1'b0, 1'b0, 1'b0);
    expectOp("srl15",   4'd7, 16'h8000, 16'h000F, 16, 16'h0001, 1'b0, 1'b0, 1'b0);
    expectOp("sll_nib", 4'd6, 16'h00FF, 16'hFFF4, 5,  16'h0FF0, 1'b0, 1'b0, 1'b0);
    expectOp("sll_out", 4'd6, 16'h8001, 16'h0001, 2,  16'h0002, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mul();
    expectOp("mul_big", 4'd8, 16'h0100, 16'h0100, 17, 16'h0000, 1'b1, 1'b1, 1'b0);
    expectOp("mul_3x5", 4'd8, 16'h0003, 16'h0005, 17, 16'h000F, 1'b0, 1'b0, 1'b0);
    expectOp("mul_max", 4'd8, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    expectOp("illegal_c", 4'hC, 16'h0005, 16'h0007, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    expectOp("illegal_f", 4'hF, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    expectOp("legal_clr", 4'd0, 16'h0002, 16'h0002, 1, 16'h0004, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    int lat;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.aluControl = 4'd8; bus.operandA = 16'h0003; bus.operandB = 16'h0005;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (c == 4);
      bus.aluControl = 4'd0; bus.operandA = 16'h0001; bus.operandB = 16'h0001;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    totalCount++;
    if (lat !== 17) $display("FAIL ignore_busy latency: got %0d expected 17", lat);
    else passCount++;
    totalCount++;
    if (bus.result !== 16'h000F) $display("FAIL ignore_busy result: got %h expected 000f", bus.result);
    else passCount++;
    // start asserted while done is high must be dropped
    bus.start = 1'b1; bus.aluControl = 4'd0; bus.operandA = 16'h0002; bus.operandB = 16'h0002;
    @(negedge clk);
    bus.start = 1'b0;
    totalCount++;
    if ({bus.done, bus.busy} !== 2'b00) $display("FAIL ignore_done after: got done=%b busy=%b expected 0/0", bus.done, bus.busy);
    else passCount++;
    @(negedge clk);
    totalCount++;
    if ({bus.done, bus.result} !== {1'b0, 16'h000F})
      $display("FAIL ignore_done hold: got done=%b res=%h expected 0/000f", bus.done, bus.result);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    expectOp("b2b_first",  4'd0, 16'h0010, 16'h0020, 1, 16'h0030, 1'b0, 1'b0, 1'b0);
    expectOp("b2b_second", 4'd4, 16'h00FF, 16'h000F, 1, 16'h00F0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    int doneSeen;
    expectOp("pre_abort", 4'd0, 16'h0001, 16'h0001, 1, 16'h0002, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.aluControl = 4'd8; bus.operandA = 16'h0100; bus.operandB = 16'h0100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    totalCount++;
    if (bus.busy !== 1'b1) $display("FAIL abort busy_before: got %b expected 1", bus.busy);
    else passCount++;
    #2 rst_n = 1'b0;
    #1;
    totalCount++;
    if ({bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.illegal} !== 21'd0)
      $display("FAIL abort async clear: got busy=%b done=%b res=%h z=%b ov=%b ill=%b expected all 0",
               bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.illegal);
    else passCount++;
    doneSeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (bus.done) doneSeen++;
    end
    totalCount++;
    if (doneSeen !== 0) $display("FAIL abort no_done: got %0d done pulses expected 0", doneSeen);
    else passCount++;
    expectOp("post_abort", 4'd0, 16'h0002, 16'h0003, 1, 16'h0005, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    passCount = 0;
    totalCount = 0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul();
    test_illegal();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
